// File: rtl/dnn_layer_if.sv
// Valid/ready bundle for the time-multiplexed fully-connected layer:
// operand vector in, NUM_OUT-wide result out.
interface dnn_layer_if #(
   parameter int IN_SIZE  = 17,
   parameter int W_SIZE   = 5,
   parameter int OUT_SIZE = 21,
   parameter int NUM_IN   = 4,
   parameter int NUM_OUT  = 2
);
   logic                              in_valid;
   logic                              in_ready;
   logic                              relu_en;
   logic [NUM_IN*IN_SIZE-1:0]         x_in;
   logic [NUM_IN*NUM_OUT*W_SIZE-1:0]  w_in;
   logic                              out_valid;
   logic                              out_ready;
   logic [NUM_OUT*OUT_SIZE-1:0]       y_out;
   logic                              busy;

   modport master (
      output in_valid, relu_en, x_in, w_in, out_ready,
      input  in_ready, out_valid, y_out, busy
   );

   modport slave (
      input  in_valid, relu_en, x_in, w_in, out_ready,
      output in_ready, out_valid, y_out, busy
   );
endinterface

// File: rtl/dnn_layer_seq.sv
// Fully-connected layer: one input element per cycle against NUM_OUT parallel
// multipliers, with optional ReLU and saturating/wrapping output narrowing.
module dnn_layer_seq #(
   parameter int IN_SIZE  = 17,
   parameter int W_SIZE   = 5,
   parameter int OUT_SIZE = 21,
   parameter int NUM_IN   = 4,
   parameter int NUM_OUT  = 2,
   parameter bit SAT      = 1'b1
) (
   input logic        clk,
   input logic        rst_n,
   dnn_layer_if.slave bus
);
   localparam int PROD_W = IN_SIZE + W_SIZE;
   localparam int ACC_W  = PROD_W + $clog2(NUM_IN);
   localparam int EXT_W  = ((ACC_W > OUT_SIZE) ? ACC_W : OUT_SIZE) + 1;
   localparam int CNT_W  = $clog2(NUM_IN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_IN - 1);
   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN =
      {{(EXT_W-OUT_SIZE+1){1'b1}}, {(OUT_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         idx_q, idx_d;
   logic signed [ACC_W-1:0]  acc_q [NUM_OUT];
   logic signed [ACC_W-1:0]  acc_d [NUM_OUT];
   logic [NUM_OUT*OUT_SIZE-1:0] y_q, y_d;
   logic                     out_valid_q, out_valid_d;
   logic                     capture;

   logic                     relu_q;
   logic signed [IN_SIZE-1:0] x_q [NUM_IN];
   logic signed [W_SIZE-1:0]  w_q [NUM_IN][NUM_OUT];

   // Exact signed product, sign-extended to accumulator width.
   function automatic logic signed [ACC_W-1:0] mul_ext(
      input logic signed [IN_SIZE-1:0] x,
      input logic signed [W_SIZE-1:0]  w
   );
      logic signed [PROD_W-1:0] p;
      p = PROD_W'(x) * PROD_W'(w);
      return ACC_W'(p);
   endfunction

   // ReLU first, then clamp (SAT) or plain truncation to OUT_SIZE bits.
   function automatic logic [OUT_SIZE-1:0] post_proc(
      input logic signed [ACC_W-1:0] acc,
      input logic                    relu
   );
      logic signed [EXT_W-1:0] v;
      v = EXT_W'(acc);
      if (relu && (v < 0)) v = '0;
      if (SAT && (v > SAT_MAX)) v = SAT_MAX;
      if (SAT && (v < SAT_MIN)) v = SAT_MIN;
      return v[OUT_SIZE-1:0];
   endfunction

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      y_d         = y_q;
      out_valid_d = out_valid_q;
      capture     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               capture = 1'b1;
               idx_d   = '0;
               for (int j = 0; j < NUM_OUT; j++) acc_d[j] = '0;
               state_d = ACC;
            end
         end
         ACC: begin
            for (int j = 0; j < NUM_OUT; j++)
               acc_d[j] = acc_q[j] + mul_ext(x_q[idx_q], w_q[idx_q][j]);
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               for (int j = 0; j < NUM_OUT; j++)
                  y_d[j*OUT_SIZE +: OUT_SIZE] = post_proc(acc_d[j], relu_q);
               out_valid_d = 1'b1;
               idx_d       = '0;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         for (int j = 0; j < NUM_OUT; j++) acc_q[j] <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         for (int j = 0; j < NUM_OUT; j++) acc_q[j] <= acc_d[j];
      end
   end

   // Private operand copy; only meaningful after an accept, so no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         relu_q <= bus.relu_en;
         for (int i = 0; i < NUM_IN; i++) begin
            x_q[i] <= bus.x_in[i*IN_SIZE +: IN_SIZE];
            for (int j = 0; j < NUM_OUT; j++)
               w_q[i][j] <= bus.w_in[(i*NUM_OUT+j)*W_SIZE +: W_SIZE];
         end
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q == ACC);
   assign bus.out_valid = out_valid_q;
   assign bus.y_out     = y_q;
endmodule
